camera_to_axis_converter_mp: RTL and testbench
==============================================

Name: camera_to_axis_converter_mp

Overview:
- Single-clock, multi-pixel-per-clock successor of the camera-to-AXIS converter.
- Turns a camera-style stream (frame-start pulse, data-valid, pixel data) into AXI4-Stream video: tuser[0] marks SOF, tlast marks EOL.
- Adds PPC/channel generalisation, frame-length enforcement, a skid FIFO with overflow detection, and line/frame error flags.
- Sits between sensor/ISP front-end and HLS vision cores.

Parameters:
- C_WIDTH, 8, bits per colour component.
- NUM_CHANNELS, 3, components per pixel (1..4).
- PPC, 1, pixels per beat (1, 2, 4).
- TUSER_WIDTH, 1, tuser width; bit 0 = SOF, other bits driven 0.
- FIFO_DEPTH, 32, output FIFO entries (power of 2, >=4).
- DIM_W, 16, width of resolution inputs and counters.

Ports:
- i_clk  in  1  clock for both sides.
- i_resetn  in  1  asynchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse before the first line of a frame.
- i_data_valid  in  1  beat valid; high for the active part of each line.
- i_data  in  PPC*NUM_CHANNELS*C_WIDTH  pixel beat; pixel 0 in LSBs.
- i_hres  in  DIM_W  active width in pixels; multiple of PPC.
- i_vres  in  DIM_W  active height in lines.
- o_tdata  out  PPC*NUM_CHANNELS*C_WIDTH  AXIS data.
- o_tvalid  out  1  AXIS valid.
- i_tready  in  1  AXIS ready.
- o_tlast  out  1  end of line.
- o_tuser  out  TUSER_WIDTH  bit 0 = start of frame.
- o_overflow  out  1  sticky: a beat was dropped because the FIFO was full.
- o_line_err  out  1  sticky: a line ended short.
- o_frame_err  out  1  sticky: frame_start arrived before i_vres lines completed.

Behaviour:
- Reset (async assert, sync deassert internally):
  - all outputs 0; FIFO empty; state IDLE; counters 0.
- State machine:
  - IDLE: beats dropped silently. i_frame_start -> SOF_PEND.
  - SOF_PEND: first valid beat is written with tuser[0]=1 -> ACTIVE.
  - ACTIVE: beats written, no tuser.
    - When line_cnt reaches i_vres (after the last tlast) -> IDLE.
    - i_frame_start in ACTIVE -> SOF_PEND, counters cleared, o_frame_err set.
- Resolution sampling:
  - i_hres/PPC and i_vres are latched on i_frame_start.
  - Mid-frame changes are ignored.
- Beat counter:
  - Increments per written beat.
  - tlast=1 on the beat where beat_cnt == hres/PPC-1; counter then wraps to 0 and line_cnt increments.
  - Long lines: extra beats simply begin the next line.
- Short line:
  - Falling edge of i_data_valid with beat_cnt != 0 sets o_line_err and clears beat_cnt.
  - line_cnt unchanged. No tlast is fabricated.
- FIFO:
  - Entry = {tuser, tlast, data}.
  - Input beat is registered once, then written; FWFT read.
  - Minimum latency: beat at cycle N appears on o_tvalid at N+2.
  - Output follows AXIS rules: o_tdata/o_tlast/o_tuser stable while o_tvalid && !i_tready.
- Full FIFO:
  - Beat is dropped and o_overflow set.
  - Beat/line counters still advance, so line geometry stays aligned.
  - A dropped tlast beat is lost; downstream sees a merged line, which o_overflow reports.
- Simultaneous events:
  - i_frame_start with i_data_valid in the same cycle: frame_start wins, the beat is dropped.
  - Write and read in the same cycle on a full FIFO: the write is accepted.
- Sticky flags clear only on reset.

Optional Feature:
- Macro CAM2AXIS_STATS_EN.
- Defined:
  - adds outputs o_frame_cnt [31:0] (increments on each IDLE entry after a completed frame);
  - adds o_drop_cnt [31:0] (dropped beats, saturating).
- Undefined:
  - ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cam2axis_pkg:
  - state enum (IDLE, SOF_PEND, ACTIVE);
  - SOF bit index constant;
  - FIFO entry width function of PPC, NUM_CHANNELS, C_WIDTH, TUSER_WIDTH.
- Sub-module: cam2axis_sync_fifo, single-clock FWFT FIFO with full/empty and async active-low reset.

Test Plan:
- Nominal stream:
  - Stimulus: PPC=2, i_hres=8, i_vres=4, i_tready=1, 3 frames.
  - Required: 16 beats per frame; tlast on beats 3,7,11,15; tuser only on beat 0; first o_tvalid 2 cycles after first beat.
- Back-pressure:
  - Stimulus: same frame, i_tready toggling 1010…, FIFO_DEPTH=32.
  - Required: no drops, data order preserved, outputs stable while stalled, o_overflow=0.
- Overflow:
  - Stimulus: i_tready=0, FIFO_DEPTH=4, 10 beats.
  - Required: first 4 beats stored, o_overflow=1 from the 5th beat's write cycle; after release, 4 beats emerge.
- Short line:
  - Stimulus: i_hres=8, PPC=1, valid drops after 5 beats, next line full.
  - Required: o_line_err=1, no tlast on beat 5, next line's tlast on its 8th beat.
- Early frame_start:
  - Stimulus: i_vres=4, i_frame_start after 2 lines.
  - Required: o_frame_err=1, next beat carries tuser=1, line count restarts.
- Reset mid-frame:
  - Stimulus: i_resetn low while the FIFO holds 3 beats.
  - Required: o_tvalid=0 immediately (asynchronously), flags cleared; beats before the next i_frame_start are dropped.

Source files
------------

// File: rtl/cam2axis_pkg.sv
// Shared definitions for the multi-pixel camera-to-AXIS converter: FSM encoding,
// tuser bit positions and FIFO entry sizing.
package cam2axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SOF_PEND = 2'd1,
    ST_ACTIVE   = 2'd2
  } cam_state_e;

  localparam int SOF_BIT = 0;

  // Entry layout is {tuser, tlast, data}
  function automatic int fifo_entry_width(input int ppc, input int nch, input int cw, input int tuw);
    return ppc * nch * cw + 1 + tuw;
  endfunction

endpackage

// File: rtl/cam2axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// A write to a full FIFO is still taken when a read frees a slot in the same cycle.
module cam2axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_rd;
  logic             do_wr;

  assign o_empty   = (wr_ptr_q == rd_ptr_q);
  assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = i_rd_en && !o_empty;
  assign do_wr     = i_wr_en && (!o_full || do_rd);
  // Data is forced to zero while empty so the outputs read 0 out of reset
  assign o_rd_data = o_empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/camera_to_axis_converter_mp.sv
// Camera stream (frame_start / data_valid / data) to AXI4-Stream video, PPC pixels per beat.
// Optional statistics outputs are enabled with CAM2AXIS_STATS_EN.
module camera_to_axis_converter_mp
  import cam2axis_pkg::*;
#(
  parameter int C_WIDTH      = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int PPC          = 1,
  parameter int TUSER_WIDTH  = 1,
  parameter int FIFO_DEPTH   = 32,
  parameter int DIM_W        = 16
) (
  input  logic                                i_clk,
  input  logic                                i_resetn,
  input  logic                                i_frame_start,
  input  logic                                i_data_valid,
  input  logic [PPC*NUM_CHANNELS*C_WIDTH-1:0] i_data,
  input  logic [DIM_W-1:0]                    i_hres,
  input  logic [DIM_W-1:0]                    i_vres,
  output logic [PPC*NUM_CHANNELS*C_WIDTH-1:0] o_tdata,
  output logic                                o_tvalid,
  input  logic                                i_tready,
  output logic                                o_tlast,
  output logic [TUSER_WIDTH-1:0]              o_tuser,
  output logic                                o_overflow,
  output logic                                o_line_err,
`ifdef CAM2AXIS_STATS_EN
  output logic                                o_frame_err,
  output logic [31:0]                         o_frame_cnt,
  output logic [31:0]                         o_drop_cnt
`else
  output logic                                o_frame_err
`endif
);
  localparam int DATA_W  = PPC * NUM_CHANNELS * C_WIDTH;
  localparam int ENTRY_W = fifo_entry_width(PPC, NUM_CHANNELS, C_WIDTH, TUSER_WIDTH);
  localparam int PPC_SH  = $clog2(PPC);
  localparam logic [DIM_W-1:0] DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

  logic [1:0]             rst_sync_q, rst_sync_d;
  logic                   rst_n;
  cam_state_e             state_q, state_d;
  logic [DIM_W-1:0]       hbeats_q, hbeats_d;
  logic [DIM_W-1:0]       vres_q, vres_d;
  logic [DIM_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [DIM_W-1:0]       line_cnt_q, line_cnt_d;
  logic                   valid_prev_q, valid_prev_d;
  logic                   stg_vld_q, stg_vld_d;
  logic [ENTRY_W-1:0]     stg_entry_q, stg_entry_d;
  logic                   overflow_q, overflow_d;
  logic                   line_err_q, line_err_d;
  logic                   frame_err_q, frame_err_d;
  logic [TUSER_WIDTH-1:0] beat_tuser;
  logic                   beat_last;
  logic                   line_last;
  logic                   fifo_rd;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   wr_drop;
  logic [ENTRY_W-1:0]     fifo_rd_data;

  // Reset asserts asynchronously but is released in step with the clock
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) rst_sync_q <= 2'b00;
    else           rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q[1];

  assign beat_last = (beat_cnt_q == hbeats_q - DIM_ONE);
  assign line_last = (line_cnt_q + DIM_ONE == vres_q);

  always_comb begin
    beat_tuser          = '0;
    beat_tuser[SOF_BIT] = (state_q == ST_SOF_PEND);
  end

  always_comb begin
    state_d      = state_q;
    hbeats_d     = hbeats_q;
    vres_d       = vres_q;
    beat_cnt_d   = beat_cnt_q;
    line_cnt_d   = line_cnt_q;
    valid_prev_d = i_data_valid;
    stg_vld_d    = 1'b0;
    stg_entry_d  = {beat_tuser, beat_last, i_data};
    overflow_d   = overflow_q | wr_drop;
    line_err_d   = line_err_q;
    frame_err_d  = frame_err_q;

    if (i_frame_start) begin
      // frame_start wins over a coincident beat, which is discarded
      state_d    = ST_SOF_PEND;
      hbeats_d   = i_hres >> PPC_SH;
      vres_d     = i_vres;
      beat_cnt_d = '0;
      line_cnt_d = '0;
      if (state_q == ST_ACTIVE) frame_err_d = 1'b1;
    end else if (state_q != ST_IDLE) begin
      if (i_data_valid) begin
        stg_vld_d = 1'b1;
        state_d   = ST_ACTIVE;
        if (beat_last) begin
          beat_cnt_d = '0;
          if (line_last) begin
            line_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            line_cnt_d = line_cnt_q + DIM_ONE;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + DIM_ONE;
        end
      end else if (valid_prev_q && (beat_cnt_q != '0)) begin
        // short line: restart the beat count, no tlast is invented
        line_err_d = 1'b1;
        beat_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hbeats_q     <= '0;
      vres_q       <= '0;
      beat_cnt_q   <= '0;
      line_cnt_q   <= '0;
      valid_prev_q <= 1'b0;
      stg_vld_q    <= 1'b0;
      stg_entry_q  <= '0;
      overflow_q   <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hbeats_q     <= hbeats_d;
      vres_q       <= vres_d;
      beat_cnt_q   <= beat_cnt_d;
      line_cnt_q   <= line_cnt_d;
      valid_prev_q <= valid_prev_d;
      stg_vld_q    <= stg_vld_d;
      stg_entry_q  <= stg_entry_d;
      overflow_q   <= overflow_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign fifo_rd = o_tvalid && i_tready;
  assign wr_drop = stg_vld_q && fifo_full && !fifo_rd;

  cam2axis_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_resetn  (rst_n),
    .i_wr_en   (stg_vld_q),
    .i_wr_data (stg_entry_q),
    .i_rd_en   (fifo_rd),
    .o_rd_data (fifo_rd_data),
    .o_empty   (fifo_empty),
    .o_full    (fifo_full)
  );

  assign o_tvalid    = !fifo_empty;
  assign o_tdata     = fifo_rd_data[DATA_W-1:0];
  assign o_tlast     = fifo_rd_data[DATA_W];
  assign o_tuser     = fifo_rd_data[DATA_W+1 +: TUSER_WIDTH];
  assign o_overflow  = overflow_q;
  assign o_line_err  = line_err_q;
  assign o_frame_err = frame_err_q;

`ifdef CAM2AXIS_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        frame_done;

  assign frame_done = !i_frame_start && (state_q != ST_IDLE) && i_data_valid && beat_last && line_last;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (frame_done) frame_cnt_d = frame_cnt_q + 32'd1;
    if (wr_drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_camera_to_axis_converter_mp.sv
// Directed bench: dut_a (PPC=2, 32-deep FIFO) and dut_b (PPC=1, 4-deep FIFO).
module tb_camera_to_axis_converter_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // dut_a signals
  logic        a_fs = 1'b0, a_dv = 1'b0, a_tready = 1'b0, a_bp = 1'b0;
  logic [47:0] a_data = '0;
  logic [15:0] a_hres = 16'd8, a_vres = 16'd4;
  logic [47:0] a_tdata;
  logic        a_tvalid, a_tlast, a_ovf, a_lerr, a_ferr;
  logic [0:0]  a_tuser;

  // dut_b signals
  logic        b_fs = 1'b0, b_dv = 1'b0, b_tready = 1'b0;
  logic [23:0] b_data = '0;
  logic [15:0] b_hres = 16'd8, b_vres = 16'd1;
  logic [23:0] b_tdata;
  logic        b_tvalid, b_tlast, b_ovf, b_lerr, b_ferr;
  logic [0:0]  b_tuser;

  camera_to_axis_converter_mp #(.PPC(2), .FIFO_DEPTH(32)) dut_a (
    .i_clk(clk), .i_resetn(rst_n), .i_frame_start(a_fs), .i_data_valid(a_dv),
    .i_data(a_data), .i_hres(a_hres), .i_vres(a_vres), .o_tdata(a_tdata),
    .o_tvalid(a_tvalid), .i_tready(a_tready), .o_tlast(a_tlast), .o_tuser(a_tuser),
    .o_overflow(a_ovf), .o_line_err(a_lerr), .o_frame_err(a_ferr)
  );

  camera_to_axis_converter_mp #(.PPC(1), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_resetn(rst_n), .i_frame_start(b_fs), .i_data_valid(b_dv),
    .i_data(b_data), .i_hres(b_hres), .i_vres(b_vres), .o_tdata(b_tdata),
    .o_tvalid(b_tvalid), .i_tready(b_tready), .o_tlast(b_tlast), .o_tuser(b_tuser),
    .o_overflow(b_ovf), .o_line_err(b_lerr), .o_frame_err(b_ferr)
  );

  // Output monitors: record accepted beats; track AXIS stability on dut_a while stalled
  logic [49:0] a_q[$], a_exp[$];
  logic [25:0] b_q[$], b_exp[$];
  logic        a_stall_prev = 1'b0;
  logic [49:0] a_prev = '0;
  int          a_stalls = 0, a_unstable = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_stall_prev <= 1'b0;
    end else begin
      if (a_stall_prev) begin
        a_stalls <= a_stalls + 1;
        if (!a_tvalid || ({a_tuser, a_tlast, a_tdata} != a_prev)) a_unstable <= a_unstable + 1;
      end
      a_stall_prev <= a_tvalid && !a_tready;
      a_prev       <= {a_tuser, a_tlast, a_tdata};
      if (a_tvalid && a_tready) a_q.push_back({a_tuser, a_tlast, a_tdata});
      if (b_tvalid && b_tready) b_q.push_back({b_tuser, b_tlast, b_tdata});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drv(input logic fs, input logic dv, input logic [47:0] d);
    step();
    a_fs = fs; a_dv = dv; a_data = d;
    if (a_bp) a_tready = ~a_tready;
  endtask

  task automatic b_drv(input logic fs, input logic dv, input logic [23:0] d);
    step();
    b_fs = fs; b_dv = dv; b_data = d;
  endtask

  task automatic cmp_a(input string tag, input int base);
    chk({tag, "_count"}, a_q.size() - base, a_exp.size());
    for (int i = 0; i < a_exp.size(); i++)
      if (base + i < a_q.size()) chk($sformatf("%s[%0d]", tag, i), a_q[base + i], a_exp[i]);
    a_exp.delete();
  endtask

  task automatic cmp_b(input string tag, input int base);
    chk({tag, "_count"}, b_q.size() - base, b_exp.size());
    for (int i = 0; i < b_exp.size(); i++)
      if (base + i < b_q.size()) chk($sformatf("%s[%0d]", tag, i), b_q[base + i], b_exp[i]);
    b_exp.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
  endtask

  function automatic logic [47:0] a_dat(input int f, input int i);
    return {8'h5A, 24'(f), 16'(i)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    // Reset state
    repeat (3) step();
    chk("rst_a_tvalid", a_tvalid, 1'b0);
    chk("rst_a_tdata", a_tdata, 48'd0);
    chk("rst_a_tlast", a_tlast, 1'b0);
    chk("rst_a_tuser", a_tuser, 1'b0);
    chk("rst_a_flags", {a_ovf, a_lerr, a_ferr}, 3'b000);
    chk("rst_b_tvalid", b_tvalid, 1'b0);
    chk("rst_b_flags", {b_ovf, b_lerr, b_ferr}, 3'b000);
    rst_n = 1'b1;
    repeat (4) step();

    // Nominal: PPC=2, 8x4 -> 4 beats per line, 3 frames with a gap after every line
    a_hres = 16'd8; a_vres = 16'd4; a_tready = 1'b1;
    base = a_q.size();
    for (int f = 0; f < 3; f++) begin
      a_drv(1'b1, 1'b0, '0);
      for (int l = 0; l < 4; l++) begin
        for (int b = 0; b < 4; b++) begin
          a_drv(1'b0, 1'b1, a_dat(f, l * 4 + b));
          a_exp.push_back({(l == 0 && b == 0), (b == 3), a_dat(f, l * 4 + b)});
          if (f == 0 && l == 0) begin
            @(negedge clk);
            chk($sformatf("nom_latency_b%0d", b), a_tvalid, (b >= 2));
          end
        end
        a_drv(1'b0, 1'b0, '0);
      end
    end
    // Frame complete: beats without a new frame_start must vanish
    a_drv(1'b0, 1'b1, a_dat(9, 0));
    a_drv(1'b0, 1'b1, a_dat(9, 1));
    repeat (8) a_drv(1'b0, 1'b0, '0);
    cmp_a("nom", base);
    chk("nom_flags", {a_ovf, a_lerr, a_ferr}, 3'b000);

    // Back-pressure: tready toggles every cycle, continuous 16-beat frame
    base = a_q.size();
    a_bp = 1'b1;
    a_drv(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      a_drv(1'b0, 1'b1, a_dat(7, i));
      a_exp.push_back({(i == 0), ((i % 4) == 3), a_dat(7, i)});
    end
    repeat (40) a_drv(1'b0, 1'b0, '0);
    a_bp = 1'b0;
    a_tready = 1'b1;
    step();
    cmp_a("bp", base);
    chk("bp_overflow", a_ovf, 1'b0);
    chk("bp_stalls_seen", (a_stalls > 0), 1'b1);
    chk("bp_unstable", a_unstable, 0);

    // Overflow: 4-deep FIFO, tready low, 10-beat line
    b_hres = 16'd10; b_vres = 16'd1; b_tready = 1'b0;
    base = b_q.size();
    b_drv(1'b1, 1'b0, '0);
    for (int k = 0; k < 10; k++) begin
      b_drv(1'b0, 1'b1, 24'h000100 + 24'(k));
      if (k < 4) b_exp.push_back({(k == 0), 1'b0, 24'h000100 + 24'(k)});
      @(negedge clk);
      chk($sformatf("ovf_flag_k%0d", k), b_ovf, (k >= 6));
    end
    repeat (4) b_drv(1'b0, 1'b0, '0);
    chk("ovf_held", b_q.size() - base, 0);
    b_tready = 1'b1;
    repeat (8) b_drv(1'b0, 1'b0, '0);
    cmp_b("ovf", base);
    chk("ovf_sticky", b_ovf, 1'b1);
    chk("ovf_line_err", b_lerr, 1'b0);

    // Short line: 5 beats, valid drops, then a full 8-beat line
    b_drv(1'b0, 1'b0, '0);
    do_reset();
    b_hres = 16'd8; b_vres = 16'd2; b_tready = 1'b1;
    base = b_q.size();
    b_drv(1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      b_drv(1'b0, 1'b1, 24'h000200 + 24'(k));
      b_exp.push_back({(k == 0), 1'b0, 24'h000200 + 24'(k)});
    end
    b_drv(1'b0, 1'b0, '0);
    b_drv(1'b0, 1'b0, '0);
    for (int k = 0; k < 8; k++) begin
      b_drv(1'b0, 1'b1, 24'h000300 + 24'(k));
      b_exp.push_back({1'b0, (k == 7), 24'h000300 + 24'(k)});
    end
    repeat (8) b_drv(1'b0, 1'b0, '0);
    cmp_b("short", base);
    chk("short_flags", {b_ovf, b_lerr, b_ferr}, 3'b010);

    // Early frame_start after 2 of 4 lines; new frame runs a full 4 lines then goes idle
    do_reset();
    b_hres = 16'd4; b_vres = 16'd4;
    base = b_q.size();
    b_drv(1'b1, 1'b0, '0);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 4; i++) begin
        b_drv(1'b0, 1'b1, 24'h000400 + 24'(l * 4 + i));
        b_exp.push_back({(l == 0 && i == 0), (i == 3), 24'h000400 + 24'(l * 4 + i)});
      end
      b_drv(1'b0, 1'b0, '0);
    end
    b_drv(1'b1, 1'b0, '0);
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 4; i++) begin
        b_drv(1'b0, 1'b1, 24'h000500 + 24'(l * 4 + i));
        b_exp.push_back({(l == 0 && i == 0), (i == 3), 24'h000500 + 24'(l * 4 + i)});
      end
      b_drv(1'b0, 1'b0, '0);
    end
    for (int i = 0; i < 4; i++) b_drv(1'b0, 1'b1, 24'h000600 + 24'(i));
    repeat (8) b_drv(1'b0, 1'b0, '0);
    cmp_b("early", base);
    chk("early_flags", {b_ovf, b_lerr, b_ferr}, 3'b001);

    // Reset mid-frame with 3 beats held in dut_a's FIFO and both error flags set
    a_hres = 16'd8; a_vres = 16'd4; a_tready = 1'b0;
    a_drv(1'b1, 1'b0, '0);
    a_drv(1'b0, 1'b1, a_dat(20, 0));
    a_drv(1'b0, 1'b1, a_dat(20, 1));
    a_drv(1'b0, 1'b0, '0);
    a_drv(1'b1, 1'b0, '0);
    a_drv(1'b0, 1'b1, a_dat(20, 2));
    repeat (4) a_drv(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("rm_pre_tvalid", a_tvalid, 1'b1);
    chk("rm_pre_flags", {a_lerr, a_ferr}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async_tvalid", a_tvalid, 1'b0);
    chk("rm_async_out", {a_tuser, a_tlast, a_tdata}, 50'd0);
    chk("rm_async_flags", {a_ovf, a_lerr, a_ferr}, 3'b000);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();
    a_tready = 1'b1;
    base = a_q.size();
    for (int i = 0; i < 3; i++) a_drv(1'b0, 1'b1, a_dat(21, i));
    repeat (6) a_drv(1'b0, 1'b0, '0);
    chk("rm_dropped_before_fs", a_q.size() - base, 0);
    a_drv(1'b1, 1'b0, '0);
    a_drv(1'b0, 1'b1, a_dat(22, 0));
    a_exp.push_back({1'b1, 1'b0, a_dat(22, 0)});
    repeat (6) a_drv(1'b0, 1'b0, '0);
    cmp_a("rm", base);
    chk("final_unstable", a_unstable, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
